// File: rtl/params_noc.sv
// Shared NoC types: flit type encoding, flit bundle, and the widths
// the router and network interfaces agree on.
package params_noc;

    localparam int FLIT_DATA_SIZE = 32;
    localparam int BUFFER_DEPTH   = 4;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t                flit_type;
        logic [FLIT_DATA_SIZE-1:0] payload;
    } flit_t;

endpackage

// File: rtl/ni_credit_counter.sv
// Credit counter against the router LOCAL input buffer; saturates at
// BUFFER_DEPTH and flags a sticky error on an unexpected extra credit.
module ni_credit_counter #(
    parameter int BUFFER_DEPTH = 4,
    parameter int CW           = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] credits_avail,
    output logic          credit_err
);

    localparam logic [CW-1:0] L_FULL = CW'(BUFFER_DEPTH);

    logic [CW-1:0] r_credits;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= L_FULL;
            r_err     <= 1'b0;
        end else begin
            if (dec && !inc) begin
                r_credits <= r_credits - 1'b1;
            end else if (inc && !dec) begin
                // A credit with a full counter means the router and we disagree.
                if (r_credits == L_FULL) begin
                    r_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + 1'b1;
                end
            end
        end
    end

    assign credits_avail = r_credits;
    assign credit_err    = r_err;

endmodule

// File: rtl/ni_packetizer.sv
// Injection NI: packet request + payload words -> head/body/tail flits.
// Define SRC_STAMP_EN to stamp SRC_X/SRC_Y into the head flit.
module ni_packetizer
    import params_noc::flit_t, params_noc::flit_type_t,
           params_noc::HEAD, params_noc::BODY,
           params_noc::TAIL, params_noc::HEADTAIL;
#(
    parameter int SRC_X          = 0,
    parameter int SRC_Y          = 0,
    parameter int X_ADDR_SIZE    = 4,
    parameter int Y_ADDR_SIZE    = 4,
    parameter int FLIT_DATA_SIZE = params_noc::FLIT_DATA_SIZE,
    parameter int MAX_BODY_FLITS = 8,
    parameter int BUFFER_DEPTH   = params_noc::BUFFER_DEPTH,
    parameter int LW             = $clog2(MAX_BODY_FLITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [X_ADDR_SIZE-1:0]    pkt_x_dest,
    input  logic [Y_ADDR_SIZE-1:0]    pkt_y_dest,
    input  logic [LW-1:0]             pkt_len,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [FLIT_DATA_SIZE-1:0] data_in,
    output logic                      flit_valid,
    output flit_t                     flit_out,
    input  logic                      credit_in,
    output logic                      credit_err
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int XA = X_ADDR_SIZE;
    localparam int YA = Y_ADDR_SIZE;
    localparam logic [LW-1:0] L_MAX = LW'(MAX_BODY_FLITS);

    typedef enum logic {
        S_IDLE,
        S_BODY
    } state_t;

    state_t                    r_state;
    logic [LW-1:0]             r_remaining;

    logic [CW-1:0]             w_credits;
    logic                      w_has_credit;
    logic                      w_pkt_fire;
    logic                      w_data_fire;
    logic                      w_issue;
    logic [LW-1:0]             w_len_clamp;
    logic [FLIT_DATA_SIZE-1:0] w_head_payload;

    ni_credit_counter #(
        .BUFFER_DEPTH (BUFFER_DEPTH),
        .CW           (CW)
    ) u_credit (
        .clk           (clk),
        .rst           (rst),
        .dec           (w_issue),
        .inc           (credit_in),
        .credits_avail (w_credits),
        .credit_err    (credit_err)
    );

    // Readiness uses the registered count only; a same-cycle credit waits.
    assign w_has_credit = (w_credits != '0);

    always_comb begin
        pkt_ready  = 1'b0;
        data_ready = 1'b0;
        if (!rst) begin
            pkt_ready  = (r_state == S_IDLE) && w_has_credit;
            data_ready = (r_state == S_BODY) && w_has_credit;
        end
    end

    assign w_pkt_fire  = pkt_valid && pkt_ready;
    assign w_data_fire = data_valid && data_ready;
    assign w_issue     = w_pkt_fire || w_data_fire;

    assign w_len_clamp = (pkt_len > L_MAX) ? L_MAX : pkt_len;

    always_comb begin
        w_head_payload = '0;
        w_head_payload[XA-1:0]    = pkt_x_dest;
        w_head_payload[XA+YA-1:XA] = pkt_y_dest;
`ifdef SRC_STAMP_EN
        w_head_payload[2*XA+YA-1:XA+YA]     = XA'(SRC_X);
        w_head_payload[2*XA+2*YA-1:2*XA+YA] = YA'(SRC_Y);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            flit_valid  <= 1'b0;
            flit_out    <= '0;
        end else begin
            flit_valid <= w_issue;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pkt_fire) begin
                        flit_out.payload <= w_head_payload;
                        r_remaining      <= w_len_clamp;
                        if (w_len_clamp == '0) begin
                            flit_out.flit_type <= HEADTAIL;
                        end else begin
                            flit_out.flit_type <= HEAD;
                            r_state            <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (w_data_fire) begin
                        flit_out.payload <= data_in;
                        r_remaining      <= r_remaining - 1'b1;
                        if (r_remaining == LW'(1)) begin
                            flit_out.flit_type <= TAIL;
                            r_state            <= S_IDLE;
                        end else begin
                            flit_out.flit_type <= BODY;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Randomized self-checking bench for ni_packetizer with a packet-level
// reference model plus directed scenarios.
module tb_ni_packetizer;

    localparam int SX   = 2;
    localparam int SY   = 1;
    localparam int MAXB = 8;
    localparam int BD   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                pkt_valid;
    logic                pkt_ready;
    logic [3:0]          pkt_x_dest;
    logic [3:0]          pkt_y_dest;
    logic [3:0]          pkt_len;
    logic                data_valid;
    logic                data_ready;
    logic [31:0]         data_in;
    logic                flit_valid;
    params_noc::flit_t   flit_out;
    logic                credit_in;
    logic                credit_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          mc;
    int          mrem;
    bit          me;
    bit          efv;
    logic [33:0] eflit;

    always #5 clk = ~clk;

    ni_packetizer #(
        .SRC_X (SX),
        .SRC_Y (SY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_x_dest (pkt_x_dest),
        .pkt_y_dest (pkt_y_dest),
        .pkt_len    (pkt_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .flit_valid (flit_valid),
        .flit_out   (flit_out),
        .credit_in  (credit_in),
        .credit_err (credit_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] head_pl(input int x, input int y);
        int p;
        p = x + 16 * y;
`ifdef SRC_STAMP_EN
        p = p + 256 * SX + 4096 * SY;
`endif
        return 32'(p);
    endfunction

    task automatic step(input bit r, input bit pv, input int x,
                        input int y, input int len, input bit dv,
                        input logic [31:0] d, input bit ci);
        bit pr;
        bit dr;
        bit iss;
        int n;
        rst        = r;
        pkt_valid  = pv;
        pkt_x_dest = 4'(x);
        pkt_y_dest = 4'(y);
        pkt_len    = 4'(len);
        data_valid = dv;
        data_in    = d;
        credit_in  = ci;
        #1;
        pr = !r && mrem == 0 && mc != 0;
        dr = !r && mrem > 0 && mc != 0;
        chk("pkt_ready", 64'(pkt_ready), 64'(pr));
        chk("data_ready", 64'(data_ready), 64'(dr));
        iss = 0;
        if (r) begin
            mc    = BD;
            mrem  = 0;
            me    = 0;
            efv   = 0;
            eflit = '0;
        end else begin
            if (pv && pr) begin
                n     = (len > MAXB) ? MAXB : len;
                eflit = {(n == 0) ? 2'd3 : 2'd0, head_pl(x, y)};
                mrem  = n;
                iss   = 1;
            end else if (dv && dr) begin
                eflit = {(mrem == 1) ? 2'd2 : 2'd1, d};
                mrem--;
                iss = 1;
            end
            efv = iss;
            if (iss && !ci) mc--;
            else if (ci && !iss) begin
                if (mc == BD) me = 1;
                else mc++;
            end
        end
        @(posedge clk);
        #2;
        chk("flit_valid", 64'(flit_valid), 64'(efv));
        chk("flit_out", 64'(flit_out), 64'(eflit));
        chk("credit_err", 64'(credit_err), 64'(me));
        chk("credits", 64'(dut.u_credit.credits_avail), 64'(mc));
    endtask

    task automatic idle(input bit ci);
        step(0, 0, 0, 0, 0, 0, 32'h0, ci);
    endtask

    initial begin
        mc = BD; mrem = 0; me = 0; efv = 0; eflit = '0;

        step(1, 0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 0);
        idle(0);

        // Single-flit packet to (3,2)
        step(0, 1, 3, 2, 0, 0, 32'h0, 0);
        chk("lit_headtail_type", 64'(flit_out.flit_type), 64'd3);
        chk("lit_headtail_xy", 64'(flit_out.payload[7:0]), 64'h23);
        chk("lit_credits_3", 64'(dut.u_credit.credits_avail), 64'd3);

        // len=3 packet runs out of credits before the last word
        step(0, 1, 1, 0, 3, 0, 32'h0, 0);
        chk("lit_head_type", 64'(flit_out.flit_type), 64'd0);
        step(0, 0, 0, 0, 0, 1, 32'hA, 0);
        chk("lit_body_a", 64'(flit_out), {2'd1, 32'hA});
        step(0, 0, 0, 0, 0, 1, 32'hB, 0);
        chk("lit_body_b", 64'(flit_out), {2'd1, 32'hB});
        step(0, 0, 0, 0, 0, 1, 32'hC, 0);
        chk("lit_stall_c", 64'(flit_valid), 64'd0);
        step(0, 0, 0, 0, 0, 1, 32'hC, 1);
        step(0, 0, 0, 0, 0, 1, 32'hC, 0);
        chk("lit_tail_c", 64'(flit_out), {2'd2, 32'hC});

        // No credits in IDLE with a pending request
        step(0, 1, 5, 5, 0, 0, 32'h0, 0);
        step(0, 1, 5, 5, 0, 0, 32'h0, 1);
        step(0, 1, 5, 5, 0, 0, 32'h0, 0);
        chk("lit_after_credit", 64'(flit_valid), 64'd1);
        idle(0);

        // Refill, then overflow the counter
        repeat (4) idle(1);
        idle(1);
        chk("lit_err_set", 64'(credit_err), 64'd1);
        idle(0);
        chk("lit_err_sticky", 64'(credit_err), 64'd1);
        step(0, 1, 4, 4, 0, 0, 32'h0, 1);
        chk("lit_issue_and_credit", 64'(dut.u_credit.credits_avail), 64'd4);
        idle(1);

        // Reset in the middle of a len=5 packet
        step(0, 1, 6, 7, 5, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h55, 0);
        chk("lit_rst_fv", 64'(flit_valid), 64'd0);
        chk("lit_rst_credits", 64'(dut.u_credit.credits_avail), 64'd4);
        step(0, 1, 2, 2, 2, 0, 32'h0, 0);
        chk("lit_fresh_head", 64'(flit_out.flit_type), 64'd0);
        step(0, 0, 0, 0, 0, 1, 32'h1, 0);
        step(0, 0, 0, 0, 0, 1, 32'h2, 0);
        repeat (3) idle(1);

        // Source stamp layout for dest (0,3)
        step(0, 1, 0, 3, 0, 0, 32'h0, 1);
`ifdef SRC_STAMP_EN
        chk("lit_stamp", 64'(flit_out.payload[15:0]), 64'h1230);
`else
        chk("lit_stamp", 64'(flit_out.payload[15:0]), 64'h0030);
`endif
        idle(0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit ci;
            r  = ($urandom_range(0, 599) == 0);
            ci = (mc < BD) && ($urandom_range(0, 99) < 45);
            step(r, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 4)),
                 $urandom_range(0, 3) != 0, $urandom, ci);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
